// File: rtl/pcs_ctrl_pkg.sv
// Shared definitions for the 1000BASE-X link bring-up controller.
// Holds the controller state encodings and the code_sync_status polarity
// constants. SYNC_OK/SYNC_FAIL must match the values the synchronization
// block drives on code_sync_status.
package pcs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_SYNC = 3'd1,
    ST_WAIT_SYNC  = 3'd2,
    ST_QUALIFY    = 3'd3,
    ST_LINK_UP    = 3'd4,
    ST_FAILED     = 3'd5
  } ctrl_state_e;

  localparam logic SYNC_OK   = 1'b1;
  localparam logic SYNC_FAIL = 1'b0;

endpackage

// File: rtl/pcs_ctrl_timer.sv
// Clearable up-counter with a terminal-match output, shared by the timed
// states of the bring-up controller.
// Ports:
//   clk     - clock
//   rst_n_i - synchronous active-low reset, clears the count
//   clr_i   - synchronous clear (wins over en_i)
//   en_i    - count up by one
//   term_i  - terminal value to compare against
//   hit_o   - high while the current count equals term_i
module pcs_ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/pcs_sync_ctrl.sv
// Link bring-up controller for the 1000BASE-X receive synchronization block.
// Pulses the sync block reset, latches its loopback setting, waits for code
// sync within a timeout, qualifies it for LINK_HOLD cycles, then reports
// link up. Losses of sync after link-up are counted; failed acquisitions
// are retried up to MAX_RETRY times before latching FAILED.
// Ports:
//   clk              - clock, all logic on posedge
//   mr_main_reset    - synchronous active-low reset
//   enable           - run bring-up; low forces IDLE
//   mr_loopback_req  - requested loopback, sampled only in IDLE
//   signal_detect    - PMD signal detect
//   code_sync_status - sync status from the synchronization block
//   sync_rst_n       - active-low reset to the synchronization block
//   sync_loopback    - latched loopback to the synchronization block
//   link_ok          - high in LINK_UP
//   link_fail        - high in FAILED
//   ctrl_state       - current state encoding
//   retry_cnt        - retries used in the current attempt sequence
//   loss_cnt         - saturating count of LINK_UP -> WAIT_SYNC drops
module pcs_sync_ctrl
  import pcs_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int SYNC_TIMEOUT = 1024,
  parameter int LINK_HOLD    = 16,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             mr_main_reset,
  input  logic             enable,
  input  logic             mr_loopback_req,
  input  logic             signal_detect,
  input  logic             code_sync_status,
  output logic             sync_rst_n,
  output logic             sync_loopback,
  output logic             link_ok,
  output logic             link_fail,
  output logic [2:0]       ctrl_state,
  output logic [1:0]       retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  // Timer must hold the largest terminal value of the three timed states.
  localparam int TMR_MAX_A = (RST_CYCLES > SYNC_TIMEOUT) ? RST_CYCLES : SYNC_TIMEOUT;
  localparam int TMR_MAX   = (TMR_MAX_A > LINK_HOLD) ? TMR_MAX_A : LINK_HOLD;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  ctrl_state_e      state_q, state_d;
  logic [1:0]       retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             sync_rst_n_q;
  logic             loopback_q;
  logic             link_ok_q;
  logic             link_fail_q;

  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_hit;
  logic [TMR_W-1:0] tmr_term;

  pcs_ctrl_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n_i (mr_main_reset),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .term_i  (tmr_term),
    .hit_o   (tmr_hit)
  );

  // Terminal value depends on which timed state is using the counter.
  always_comb begin
    tmr_term = '0;
    case (state_q)
      ST_RESET_SYNC: tmr_term = TMR_W'(RST_CYCLES - 1);
      ST_WAIT_SYNC:  tmr_term = TMR_W'(SYNC_TIMEOUT - 1);
      ST_QUALIFY:    tmr_term = TMR_W'(LINK_HOLD - 1);
      default:       tmr_term = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          retry_d = '0;
          tmr_clr = 1'b1;
          state_d = ST_RESET_SYNC;
        end
        ST_RESET_SYNC: begin
          if (tmr_hit) begin
            tmr_clr = 1'b1;
            state_d = ST_WAIT_SYNC;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_WAIT_SYNC: begin
          // Sync checked first so it beats a timeout in the same cycle.
          if (code_sync_status == SYNC_OK) begin
            tmr_clr = 1'b1;
            state_d = ST_QUALIFY;
          end else if (!signal_detect && !loopback_q) begin
            // No light and no loopback: freeze so no retry is burned.
            tmr_en = 1'b0;
          end else if (tmr_hit) begin
            if (retry_q == 2'(MAX_RETRY)) begin
              state_d = ST_FAILED;
            end else begin
              retry_d = retry_q + 2'd1;
              tmr_clr = 1'b1;
              state_d = ST_RESET_SYNC;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_QUALIFY: begin
          if (code_sync_status == SYNC_FAIL) begin
            tmr_clr = 1'b1;
            state_d = ST_WAIT_SYNC;
          end else if (tmr_hit) begin
            retry_d = '0;
            tmr_clr = 1'b1;
            state_d = ST_LINK_UP;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_LINK_UP: begin
          // Sync block is left running; it re-acquires on its own.
          if (code_sync_status == SYNC_FAIL) begin
            if (loss_q != {CNT_W{1'b1}}) begin
              loss_d = loss_q + CNT_W'(1);
            end
            tmr_clr = 1'b1;
            state_d = ST_WAIT_SYNC;
          end
        end
        ST_FAILED: begin
          tmr_clr = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!mr_main_reset) begin
      state_q      <= ST_IDLE;
      retry_q      <= '0;
      loss_q       <= '0;
      sync_rst_n_q <= 1'b0;
      loopback_q   <= 1'b0;
      link_ok_q    <= 1'b0;
      link_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      sync_rst_n_q <= (state_d == ST_WAIT_SYNC) || (state_d == ST_QUALIFY) ||
                      (state_d == ST_LINK_UP);
      link_ok_q    <= (state_d == ST_LINK_UP);
      link_fail_q  <= (state_d == ST_FAILED);
      if (state_q == ST_IDLE) begin
        loopback_q <= mr_loopback_req;
      end
    end
  end

  assign sync_rst_n    = sync_rst_n_q;
  assign sync_loopback = loopback_q;
  assign link_ok       = link_ok_q;
  assign link_fail     = link_fail_q;
  assign ctrl_state    = state_q;
  assign retry_cnt     = retry_q;
  assign loss_cnt      = loss_q;

endmodule
